// File: rtl/multu_hilo.sv
// Sequential 32x32 unsigned shift-add multiplier with HI/LO result registers.
// One iteration per clock; the product is committed to HI/LO only on an open request.
module multu_hilo #(
  parameter int         WIDTH        = 32,
  parameter logic [5:0] OP_MULTU     = 6'd25,
  parameter logic [5:0] OP_OPEN_HILO = 6'd63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       SignaltoMULTU,
  input  logic [1:0]       SelHilo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 pending_q, pending_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (SignaltoMULTU == OP_MULTU) begin
          mcand_d   = {{WIDTH{1'b0}}, dataA};
          mplier_d  = dataB;
          prod_d    = '0;
          count_d   = '0;
          pending_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        // An early open is remembered so the commit follows the last iteration directly.
        if (SignaltoMULTU == OP_OPEN_HILO) pending_d = 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (pending_q || (SignaltoMULTU == OP_OPEN_HILO)) begin
          hi_d      = prod_q[2*WIDTH-1:WIDTH];
          lo_d      = prod_q[WIDTH-1:0];
          pending_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;

  always_comb begin
    dataOut = '0;
    case (SelHilo)
      2'b01:   dataOut = hi_q;
      2'b10:   dataOut = lo_q;
      default: dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_multu_hilo.sv
// Bench for multu_hilo: an arithmetic model checked every cycle, plus literal spot checks.
module tb_multu_hilo;

  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_OPEN  = 6'd63;

  logic        clk, rst_n;
  logic [31:0] dataA, dataB, dataOut;
  logic [5:0]  op;
  logic [1:0]  sel;
  logic        busy, done;

  multu_hilo dut (
    .clk(clk), .rst_n(rst_n), .dataA(dataA), .dataB(dataB),
    .SignaltoMULTU(op), .SelHilo(sel), .busy(busy), .done(done), .dataOut(dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: remaining busy cycles, a waiting product, and committed HI/LO.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_prod;
  int          m_left;
  logic        m_wait, m_pend, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= 0; m_lo <= 0; m_prod <= 0; m_left <= 0;
      m_wait <= 0; m_pend <= 0; m_done <= 0;
    end else begin
      m_done <= 0;
      if (m_left != 0) begin
        if (op == OP_OPEN) m_pend <= 1;
        m_left <= m_left - 1;
        if (m_left == 1) m_wait <= 1;
      end else if (m_wait) begin
        if (m_pend || op == OP_OPEN) begin
          m_hi <= m_prod[63:32]; m_lo <= m_prod[31:0];
          m_done <= 1; m_wait <= 0; m_pend <= 0;
        end
      end else if (op == OP_MULTU) begin
        m_prod <= 64'(dataA) * 64'(dataB);
        m_left <= 32;
        m_pend <= 0;
      end
    end
  end

  // Literal checks are posted by the stimulus and evaluated here.
  int          lit_seq = 0;
  logic [63:0] lit_got, lit_exp;
  string       lit_name;

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    int seen;
    logic [31:0] exp_out;
    seen = 0;
    forever begin
      @(negedge clk);
      exp_out = (sel == 2'b01) ? m_hi : (sel == 2'b10) ? m_lo : 32'h0;
      cmp("busy", 64'(busy), 64'(m_left != 0));
      cmp("done", 64'(done), 64'(m_done));
      cmp("dataOut", 64'(dataOut), 64'(exp_out));
      if (lit_seq != seen) begin
        seen = lit_seq;
        cmp(lit_name, lit_got, lit_exp);
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic post(input string name, input logic [63:0] got, input logic [63:0] exp);
    lit_got = got; lit_exp = exp; lit_name = name;
    lit_seq++;
    tick();
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    dataA = a; dataB = b; op = OP_MULTU;
    tick();
    op = 6'd0;
  endtask

  // Counts busy cycles; optionally opens early or disturbs the inputs at a given cycle.
  task automatic run_loop(input int open_at, input int chg_at, output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      if (cnt == open_at) op = OP_OPEN;
      else if (cnt == chg_at) begin op = OP_MULTU; dataA = 32'd9; dataB = 32'd9; end
      else op = 6'd0;
      cnt++;
      tick();
    end
    op = 6'd0;
  endtask

  task automatic open_commit(input string name);
    op = OP_OPEN;
    tick();
    op = 6'd0;
    post(name, 64'(done), 64'd1);
    post({name, "_clr"}, 64'(done), 64'd0);
  endtask

  task automatic read(input string name, input logic [1:0] s, input logic [31:0] exp);
    sel = s; #1;
    post(name, 64'(dataOut), 64'(exp));
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; dataA = 0; dataB = 0; op = 6'd0; sel = 2'b01;
    repeat (2) tick();
    post("rst_dataOut", 64'(dataOut), 64'd0);
    post("rst_busy", 64'(busy), 64'd0);
    post("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    // 3*5 with a late open
    start(32'd3, 32'd5);
    run_loop(-1, -1, cnt);
    post("t1_busy_cycles", 64'(cnt), 64'd32);
    post("t1_no_done_wait", 64'(done), 64'd0);
    open_commit("t1_done");
    read("t1_lo", 2'b10, 32'd15);
    read("t1_hi", 2'b01, 32'd0);

    // all-ones operands
    start(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_loop(-1, -1, cnt);
    post("t2_busy_cycles", 64'(cnt), 64'd32);
    open_commit("t2_done");
    read("t2_hi", 2'b01, 32'hFFFFFFFE);
    read("t2_lo", 2'b10, 32'h00000001);

    // early open during RUN: commit on the edge after the last iteration
    start(32'h12345678, 32'h9ABCDEF0);
    run_loop(29, -1, cnt);
    post("t3_busy_cycles", 64'(cnt), 64'd32);
    post("t3_done", 64'(done), 64'd1);
    post("t3_done_clr", 64'(done), 64'd0);
    read("t3_hi", 2'b01, 32'h0B00EA4E);
    read("t3_lo", 2'b10, 32'h242D2080);

    // unselected reads and an open held in IDLE
    read("t6_sel11", 2'b11, 32'd0);
    read("t6_sel00", 2'b00, 32'd0);
    op = OP_OPEN;
    repeat (3) post("t6_idle_open_done", 64'(done), 64'd0);
    op = 6'd0;
    read("t6_hi_kept", 2'b01, 32'h0B00EA4E);
    read("t6_lo_kept", 2'b10, 32'h242D2080);

    // reset mid-run
    start(32'h1111, 32'h2222);
    repeat (9) tick();
    rst_n = 1'b0; #1;
    post("t4_rst_busy", 64'(busy), 64'd0);
    read("t4_rst_hi", 2'b01, 32'd0);
    read("t4_rst_lo", 2'b10, 32'd0);
    rst_n = 1'b1;
    tick();
    start(32'd7, 32'd6);
    run_loop(-1, -1, cnt);
    post("t4_busy_cycles", 64'(cnt), 64'd32);
    open_commit("t4_done");
    read("t4_lo", 2'b10, 32'd42);

    // operand changes and a second start during RUN are ignored
    start(32'd100, 32'd200);
    run_loop(-1, 5, cnt);
    post("t5_busy_cycles", 64'(cnt), 64'd32);
    open_commit("t5_done");
    read("t5_lo", 2'b10, 32'd20000);
    read("t5_hi", 2'b01, 32'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
